// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous video RAM between display scan-out and two host ports
//
// Display fetches take absolute priority. Host write/read ports use the remaining cycles and are
// arbitrated round-robin when both are valid. Pixels and syncs leave two cycles after the
// coordinates that produced them.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   x, y, active             pixel coordinate and visible flag from the timing generator
//   hsync_in, vsync_in       active-low syncs from the timing generator
//   mem_addr/we/wdata        RAM request (combinational)
//   mem_rdata                RAM read data, one cycle after the address
//   wr_valid/ready/addr/data host write port
//   rd_valid/ready/addr      host read-request port
//   rd_data, rd_data_valid   host read result and its one-cycle update pulse
//   pix, pix_active          pixel output and visible flag, 2-cycle latency
//   hsync_out, vsync_out     syncs delayed to match pix
module vga_vram_arbiter #(
    parameter int PIX_W       = 4,
    parameter int WORD_PIX    = 4,
    parameter int ADDR_W      = 17,
    parameter int H_DISPLAY   = 640,
    parameter int V_DISPLAY   = 480,
    parameter int VBLANK_ONLY = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      active,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [PIX_W*WORD_PIX-1:0] mem_wdata,
    input  logic [PIX_W*WORD_PIX-1:0] mem_rdata,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [PIX_W*WORD_PIX-1:0] wr_data,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [PIX_W*WORD_PIX-1:0] rd_data,
    output logic                      rd_data_valid,
    output logic [PIX_W-1:0]          pix,
    output logic                      pix_active,
    output logic                      hsync_out,
    output logic                      vsync_out
);
    localparam int         WORD_W = PIX_W * WORD_PIX;
    localparam int         SEL_W  = WORD_PIX > 1 ? $clog2(WORD_PIX) : 1;
    localparam logic [9:0] V_LIM  = 10'(V_DISPLAY);

    // Catch a RAM too small for one frame or a line width that is not a whole number of words.
    generate
        if ((H_DISPLAY % WORD_PIX) != 0 || (H_DISPLAY / WORD_PIX) * V_DISPLAY > 2 ** ADDR_W) begin : g_bad_geometry
            $error("vga_vram_arbiter: frame geometry does not fit the word/address configuration");
        end
    endgenerate

    logic [SEL_W-1:0]  sel, sel_d1;
    logic              fetch, fetch_d1, host_ok, grant_w, grant_r, rd_d1, last_rd;
    logic [ADDR_W-1:0] wcnt, disp_addr;
    logic [WORD_W-1:0] word_q, word;
    logic [1:0]        act_d, hs_d, vs_d;

    assign sel = SEL_W'(x % WORD_PIX);

    always_comb begin
        fetch     = active && sel == '0;
        // The counter register still holds last frame's end at (0,0), so the restart is applied here.
        disp_addr = (x == '0 && y == '0) ? '0 : wcnt;
        host_ok   = !rst && !fetch && (VBLANK_ONLY == 0 || y >= V_LIM);
        grant_w   = host_ok && wr_valid && (!rd_valid || last_rd);
        grant_r   = host_ok && rd_valid && (!wr_valid || !last_rd);
        mem_addr  = grant_w ? wr_addr : grant_r ? rd_addr : disp_addr;
        mem_we    = grant_w;
        mem_wdata = wr_data;
        wr_ready  = grant_w;
        rd_ready  = grant_r;
        // The first pixel of a word comes straight from the RAM; the rest from the held copy,
        // which only reloads after a fetch so host reads in between cannot corrupt it.
        word      = fetch_d1 ? mem_rdata : word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt          <= '0;
            last_rd       <= 1'b1;
            fetch_d1      <= 1'b0;
            rd_d1         <= 1'b0;
            sel_d1        <= '0;
            word_q        <= '0;
            act_d         <= '0;
            hs_d          <= 2'b11;
            vs_d          <= 2'b11;
            pix           <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            wcnt          <= disp_addr + ADDR_W'(fetch);
            if (grant_w || grant_r) last_rd <= grant_r;
            fetch_d1      <= fetch;
            rd_d1         <= grant_r;
            sel_d1        <= sel;
            if (fetch_d1) word_q <= mem_rdata;
            act_d         <= {act_d[0], active};
            hs_d          <= {hs_d[0], hsync_in};
            vs_d          <= {vs_d[0], vsync_in};
            pix           <= act_d[0] ? word[int'(sel_d1)*PIX_W +: PIX_W] : '0;
            rd_data_valid <= rd_d1;
            if (rd_d1) rd_data <= mem_rdata;
        end
    end

    assign pix_active = act_d[1];
    assign hsync_out  = hs_d[1];
    assign vsync_out  = vs_d[1];
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed self-checking bench for vga_vram_arbiter with a behavioural RAM
//
// Ports: none. Drives the arbiter with a hand-written timing sequence; a second instance with
// tear-free host access shares the inputs.
module tb_vga_vram_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [9:0]  x, y;
    logic        active, hsync_in, vsync_in;
    logic [16:0] mem_addr, wr_addr, rd_addr, ld_addr;
    logic        mem_we, wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid;
    logic [15:0] mem_wdata, mem_rdata, wr_data, rd_data, ld_data;
    logic [3:0]  pix;
    logic        pix_active, hsync_out, vsync_out, ld;
    logic [16:0] vb_mem_addr;
    logic        vb_mem_we, vb_wr_ready, vb_rd_ready, vb_rd_data_valid;
    logic [15:0] vb_mem_wdata, vb_rd_data;
    logic [15:0] vb_rdata = '0;
    logic [3:0]  vb_pix;
    logic        vb_pix_active, vb_hsync_out, vb_vsync_out;
    logic [15:0] ram [0:131071];
    int          vecs = 0, errs = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    vga_vram_arbiter dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .pix(pix), .pix_active(pix_active),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    vga_vram_arbiter #(.VBLANK_ONLY(1)) dut_vb (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mem_addr(vb_mem_addr), .mem_we(vb_mem_we), .mem_wdata(vb_mem_wdata), .mem_rdata(vb_rdata),
        .wr_valid(wr_valid), .wr_ready(vb_wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(1'b0), .rd_ready(vb_rd_ready), .rd_addr(rd_addr), .rd_data(vb_rd_data),
        .rd_data_valid(vb_rd_data_valid), .pix(vb_pix), .pix_active(vb_pix_active),
        .hsync_out(vb_hsync_out), .vsync_out(vb_vsync_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    initial begin
        x = '0; y = 10'd500; active = 0; hsync_in = 1; vsync_in = 1;
        wr_valid = 0; rd_valid = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        ld = 0; ld_addr = '0; ld_data = '0;
        tick;
        ld = 1; ld_addr = 17'd0; ld_data = 16'h4321;
        tick;
        ld_addr = 17'd7; ld_data = 16'hBEEF;
        tick;
        ld = 0; rst = 0;

        // reset in the middle of host traffic
        hsync_in = 0; vsync_in = 0;
        wr_valid = 1; wr_addr = 17'd100; wr_data = 16'h1234;
        rd_valid = 1; rd_addr = 17'd7;
        repeat (4) tick;
        chk("pre-reset rd_data", rd_data, 16'hBEEF);
        chk("pre-reset hsync_out", hsync_out, 0);
        rst = 1;
        #1;
        chk("rst pix", pix, 0);
        chk("rst pix_active", pix_active, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst rd_data_valid", rd_data_valid, 0);
        chk("rst hsync_out", hsync_out, 1);
        chk("rst vsync_out", vsync_out, 1);
        chk("rst wr_ready", wr_ready, 0);
        chk("rst rd_ready", rd_ready, 0);
        chk("rst mem_we", mem_we, 0);
        tick;
        rst = 0;

        // round-robin in blanking: W,R,W,R,W
        for (int c = 0; c < 5; c++) begin
            settle;
            chk("rr wr_ready", wr_ready, (c % 2 == 0));
            chk("rr rd_ready", rd_ready, (c % 2 == 1));
            if (c == 0) begin
                chk("rr mem_we", mem_we, 1);
                chk("rr wr mem_addr", mem_addr, 17'd100);
                chk("rr mem_wdata", mem_wdata, 16'h1234);
            end
            if (c == 1) chk("rr rd mem_addr", mem_addr, 17'd7);
            if (c == 2) begin
                chk("rd_data_valid early", rd_data_valid, 0);
                chk("rd_data held", rd_data, 0);
            end
            if (c == 3) begin
                chk("rd_data_valid", rd_data_valid, 1);
                chk("rd_data", rd_data, 16'hBEEF);
            end
            if (c == 4) chk("rd_data_valid pulse", rd_data_valid, 0);
            tick;
        end

        // first word of the frame, pixels LSB first
        wr_valid = 0; rd_valid = 0; vsync_in = 1;
        for (int c = 0; c < 7; c++) begin
            x = 10'(c); y = '0; active = (c < 4); hsync_in = (c != 1);
            settle;
            if (c == 0) begin
                chk("fetch mem_addr 0", mem_addr, 0);
                chk("fetch mem_we", mem_we, 0);
            end
            if (c >= 2) begin
                chk("pix", pix, (c < 6) ? c - 1 : 0);
                chk("pix_active", pix_active, (c < 6));
                chk("hsync_out delay", hsync_out, (c != 3));
            end
            tick;
        end

        // host write blocked on fetch, granted on the next cycle
        wr_valid = 1; wr_addr = 17'h1ABCD; wr_data = 16'hCAFE;
        active = 1; y = 10'd10; x = 10'd4;
        settle;
        chk("fetch wr_ready", wr_ready, 0);
        chk("fetch blocks mem_we", mem_we, 0);
        tick;
        x = 10'd5;
        settle;
        chk("gap wr_ready", wr_ready, 1);
        chk("gap mem_we", mem_we, 1);
        chk("gap mem_addr", mem_addr, 17'h1ABCD);
        chk("gap mem_wdata", mem_wdata, 16'hCAFE);
        tick;

        // tear-free instance waits for vertical blanking
        x = 10'd5; y = 10'd100;
        settle;
        chk("vblank-only visible", vb_wr_ready, 0);
        chk("any-cycle visible", wr_ready, 1);
        tick;
        x = 10'd639; y = 10'd479;
        settle;
        chk("vblank-only last line", vb_wr_ready, 0);
        tick;
        x = 10'd0; y = 10'd480; active = 0;
        settle;
        chk("vblank-only blanking", vb_wr_ready, 1);
        tick;
        wr_valid = 0;

        // full-frame address walk, fetch cycles only
        rd_valid = 1; rd_addr = 17'd7;
        for (int yy = 0; yy < 480; yy++) begin
            for (int xi = 0; xi < 160; xi++) begin
                x = 10'(xi * 4); y = 10'(yy); active = 1;
                settle;
                if (xi == 159 && yy == 0) begin
                    chk("walk addr 159", mem_addr, 17'd159);
                    chk("walk fetch rd_ready", rd_ready, 0);
                end
                if (xi == 0 && yy == 1) chk("walk addr 160", mem_addr, 17'd160);
                if (xi == 159 && yy == 479) chk("walk addr 76799", mem_addr, 17'd76799);
                tick;
            end
        end
        rd_valid = 0;
        x = '0; y = '0; active = 1;
        settle;
        chk("walk wrap to 0", mem_addr, 0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
